// File: rtl/bitmem_pkg.sv
// Shared types and sizes for the 16x1 bit-memory sequencer and its memory.
// Latency: none (package only).
// Backpressure: none (package only).
package bitmem_pkg;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      WRVERIFY = 1'b0,
      RDONLY   = 1'b1
   } mode_e;

endpackage

// File: rtl/bitmem_sequencer_if.sv
// Bit-serial memory port: one write and one combinational read address per cycle.
// Latency: write lands on the clock edge; read data is same-cycle.
// Backpressure: none, the memory always accepts.
// Modports: master = sequencer side (drives wen/waddr/wdata/raddr),
//           slave  = memory side (returns rdata).
interface bitmem_sequencer_if;
   import bitmem_pkg::*;

   logic          wen;
   logic [AW-1:0] waddr;
   logic          wdata;
   logic [AW-1:0] raddr;
   logic          rdata;

   modport master (output wen, waddr, wdata, raddr, input rdata);
   modport slave  (input wen, waddr, wdata, raddr, output rdata);

endinterface

// File: rtl/bitmem_sequencer_mem.sv
// 16x1 memory responder: synchronous write, combinational read.
// Latency: write visible on the cycle after wen; read is zero-cycle.
// Backpressure: none.
// Ports: clk; mem (slave modport of bitmem_sequencer_if).
module bitmem_sequencer_mem
   import bitmem_pkg::*;
(
   input logic                clk,
   bitmem_sequencer_if.slave  mem
);

   logic [DEPTH-1:0] mem_q;
   logic [DEPTH-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (mem.wen) begin
         mem_d[mem.waddr] = mem.wdata;
      end
   end

   // Storage has no reset: contents are only meaningful once written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign mem.rdata = mem_q[mem.raddr];

endmodule

// File: rtl/bitmem_sequencer.sv
// Writes a 16-bit word bit-serially into a 16x1 memory, reads it back, flags mismatch.
// Latency: 32 cycles acceptance->rsp_valid_o in write-verify mode, 16 in read-only mode.
// Backpressure: req_ready_o only in IDLE; response held stable until rsp_ready_i.
// Ports: clk/rst; req_* request handshake (valid/ready, mode, data);
//        rsp_* response handshake (valid/ready, data, err); mem_* memory port.
module bitmem_sequencer
   import bitmem_pkg::*;
#(
   parameter int DEPTH = bitmem_pkg::DEPTH,
   parameter int AW    = bitmem_pkg::AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_mode_i,
   input  logic [DEPTH-1:0] req_data_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [DEPTH-1:0] rsp_data_o,
   output logic             rsp_err_o,
   output logic             mem_wen_o,
   output logic [AW-1:0]    mem_waddr_o,
   output logic             mem_wdata_o,
   output logic [AW-1:0]    mem_raddr_o,
   input  logic             mem_rdata_i
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [DEPTH-1:0] data_q, data_d;
   logic [DEPTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic             idx_last;

   assign idx_last = (idx_q == AW'(DEPTH - 1));

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      idx_d       = idx_q;
      data_d      = data_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      mem_wen_o   = 1'b0;
      mem_waddr_o = '0;
      mem_wdata_o = 1'b0;
      mem_raddr_o = '0;

      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               data_d  = req_data_i;
               mode_d  = mode_e'(req_mode_i);
               idx_d   = '0;
               state_d = req_mode_i ? READ : WRITE;
            end
         end
         WRITE: begin
            // Gated by rst so the write in flight when reset is sampled never lands.
            mem_wen_o   = ~rst;
            mem_waddr_o = idx_q;
            mem_wdata_o = data_q[idx_q];
            // Index wraps 15->0 exactly on the edge that leaves this state.
            idx_d       = idx_q + 1'b1;
            if (idx_last) begin
               state_d = READ;
            end
         end
         READ: begin
            mem_raddr_o        = idx_q;
            rsp_data_d[idx_q]  = mem_rdata_i;
            idx_d              = idx_q + 1'b1;
            if (idx_last) begin
               state_d   = RESP;
               // Compare the complete word including the bit captured this cycle.
               rsp_err_d = (mode_q == WRVERIFY) && (rsp_data_d != data_q);
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= WRVERIFY;
         idx_q      <= '0;
         data_q     <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rsp_data_o = rsp_data_q;
   assign rsp_err_o  = rsp_err_q;

endmodule

// File: tb/tb_bitmem_sequencer.sv
// Testbench for bitmem_sequencer with the 16x1 memory as responder.
// Latency: n/a.
// Backpressure: exercises held rsp_ready_i and ignored req_valid_i.
module tb_bitmem_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_mode = 1'b0;
   logic [15:0] req_data = '0;
   logic        rsp_ready = 1'b1;
   logic        req_ready_o;
   logic        rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        rsp_err_o;
   logic        mem_rdata;
   logic        force7 = 1'b0;

   int errors = 0;
   int checks = 0;

   // Reference contents of the memory, updated from the expected write schedule.
   logic [15:0] ref_mem = '0;

   always #5 clk = ~clk;

   bitmem_sequencer_if mif ();

   bitmem_sequencer_mem u_mem (
      .clk (clk),
      .mem (mif.slave)
   );

   // Entry 7 can be forced to read as 0 to model a stuck bit.
   assign mem_rdata = mif.rdata & ~(force7 && (mif.raddr == 4'd7));

   bitmem_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_mode_i  (req_mode),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .mem_wen_o   (mif.wen),
      .mem_waddr_o (mif.waddr),
      .mem_wdata_o (mif.wdata),
      .mem_raddr_o (mif.raddr),
      .mem_rdata_i (mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction; hold = number of extra RESP cycles with rsp_ready low.
   task automatic run_req(input logic mode, input logic [15:0] data, input logic f7,
                          input int hold);
      int          c;
      int          lat;
      bit          done;
      logic        ew;
      logic        exp_wdata;
      logic [3:0]  exp_waddr;
      logic [3:0]  exp_raddr;
      logic [15:0] exp_rd;
      logic        exp_err;

      lat    = mode ? 16 : 32;
      force7 = f7;
      @(posedge clk); #1;
      rsp_ready = (hold == 0);
      req_valid = 1'b1;
      req_mode  = mode;
      req_data  = data;
      @(negedge clk);
      check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
      @(posedge clk); #1;
      // Request inputs are free to change after acceptance.
      req_valid = 1'b0;
      req_mode  = 1'($urandom_range(0, 1));
      req_data  = 16'($urandom);

      c    = -1;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         c++;
         ew        = (mode == 1'b0) && (c < 16);
         exp_waddr = ew ? 4'(c) : 4'd0;
         exp_wdata = ew ? data[c] : 1'b0;
         if (mode == 1'b0)
            exp_raddr = (c >= 16 && c < 32) ? 4'(c - 16) : 4'd0;
         else
            exp_raddr = (c < 16) ? 4'(c) : 4'd0;
         check("rsp_valid_timing", {31'd0, rsp_valid_o}, {31'd0, (c == lat)});
         check("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
         check("mem_wen", {31'd0, mif.wen}, {31'd0, ew});
         check("mem_waddr", {28'd0, mif.waddr}, {28'd0, exp_waddr});
         check("mem_wdata", {31'd0, mif.wdata}, {31'd0, exp_wdata});
         check("mem_raddr", {28'd0, mif.raddr}, {28'd0, exp_raddr});
         if (ew) ref_mem[c] = data[c];
         if (rsp_valid_o || c >= lat) done = 1'b1;
      end
      check("latency", 32'(c), 32'(lat));

      exp_rd = ref_mem;
      if (f7) exp_rd[7] = 1'b0;
      exp_err = (mode == 1'b0) && (exp_rd != data);
      check("rsp_data", {16'd0, rsp_data_o}, {16'd0, exp_rd});
      check("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});

      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1;
         req_mode  = 1'($urandom_range(0, 1));
         req_data  = 16'($urandom);
         @(negedge clk);
         check("hold_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
         check("hold_rsp_data", {16'd0, rsp_data_o}, {16'd0, exp_rd});
         check("hold_rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
         check("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
         check("hold_mem_wen", {31'd0, mif.wen}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("post_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("post_mem_wen", {31'd0, mif.wen}, 32'd0);
   endtask

   // Write-verify aborted by reset while writing index 5.
   task automatic run_abort(input logic [15:0] data);
      force7 = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_mode  = 1'b0;
      req_data  = data;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         check("abort_wen", {31'd0, mif.wen}, 32'd1);
         check("abort_waddr", {28'd0, mif.waddr}, 32'(c));
         if (c < 5) ref_mem[c] = data[c];
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("abort_wen_off", {31'd0, mif.wen}, 32'd0);
      check("abort_rsp_data", {16'd0, rsp_data_o}, 32'd0);
      check("abort_rsp_err", {31'd0, rsp_err_o}, 32'd0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("abort_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
         check("abort_no_wen", {31'd0, mif.wen}, 32'd0);
      end
   endtask

   initial begin
      logic        m;
      logic        f;
      logic [15:0] d;
      int          h;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      check("rst_mem_wen", {31'd0, mif.wen}, 32'd0);
      check("rst_mem_waddr", {28'd0, mif.waddr}, 32'd0);
      check("rst_mem_wdata", {31'd0, mif.wdata}, 32'd0);
      check("rst_mem_raddr", {28'd0, mif.raddr}, 32'd0);
      check("rst_rsp_data", {16'd0, rsp_data_o}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);

      run_req(1'b0, 16'hA5C3, 1'b0, 0);
      run_req(1'b1, 16'h0000, 1'b0, 0);
      run_req(1'b0, 16'hFFFF, 1'b1, 0);
      run_req(1'b0, 16'($urandom), 1'b0, 10);
      run_abort(~ref_mem);
      run_req(1'b1, 16'h0000, 1'b0, 0);

      for (int it = 0; it < 20; it++) begin
         m = 1'($urandom_range(0, 1));
         d = 16'($urandom);
         f = ($urandom_range(0, 3) == 0);
         h = $urandom_range(0, 3);
         run_req(m, d, f, h);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bitmem_sequencer.md
BITMEM_SEQUENCER -- requirements
Module: bitmem_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of 1-bit memory entries; this block supports only 16.
REQ-002 SHALL have parameter AW, default 4, meaning the memory address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  in  1  meaning the request is offered.
REQ-006 SHALL have port req_ready_o  out  1  meaning the block can accept a request.
REQ-007 SHALL have port req_mode_i  in  1  meaning 0 = write-then-verify, 1 = read-only.
REQ-008 SHALL have port req_data_i  in  16  meaning the word to write; bit k goes to address k.
REQ-009 SHALL have port rsp_valid_o  out  1  meaning a response is held.
REQ-010 SHALL have port rsp_ready_i  in  1  meaning the consumer accepts the response.
REQ-011 SHALL have port rsp_data_o  out  16  meaning the readback word; bit k comes from address k.
REQ-012 SHALL have port rsp_err_o  out  1  meaning the readback differs from the written word.
REQ-013 SHALL have port mem_wen_o  out  1  meaning the memory write enable.
REQ-014 SHALL have port mem_waddr_o  out  4  meaning the memory write address.
REQ-015 SHALL have port mem_wdata_o  out  1  meaning the memory write data.
REQ-016 SHALL have port mem_raddr_o  out  4  meaning the memory read address.
REQ-017 SHALL have port mem_rdata_i  in  1  meaning the memory read data, combinational from mem_raddr_o in the same cycle.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, RESP.
REQ-019 SHALL assert req_ready_o only in IDLE.
REQ-020 SHALL, on accepting a request (req_valid_i & req_ready_o), latch req_data_i and req_mode_i, clear index k to 0, and go to WRITE if mode=0 or READ if mode=1.
REQ-021 SHALL, in WRITE for k=0..15, drive mem_wen_o=1, mem_waddr_o=k, mem_wdata_o=latched data[k], one address per cycle, then go to READ with k=0.
REQ-022 SHALL, in READ for k=0..15, drive mem_raddr_o=k and capture mem_rdata_i into rsp_data_o[k] at that edge, then go to RESP.
REQ-023 SHALL drive mem_wen_o=0 in every state except WRITE; mem_waddr_o, mem_wdata_o and mem_raddr_o are 0 outside their active states.
REQ-024 SHALL assert rsp_valid_o only in RESP and hold rsp_data_o and rsp_err_o stable until rsp_valid_o & rsp_ready_i, then return to IDLE.
REQ-025 SHALL set rsp_err_o = (readback != latched data) in mode 0 and rsp_err_o = 0 in mode 1.
REQ-026 SHALL have latency, from the acceptance edge to the first cycle of rsp_valid_o, of 32 cycles in mode 0 and 16 in mode 1.
REQ-027 SHALL wrap the 4-bit index from 15 to 0 only on a state transition, never within a state.
REQ-028 SHALL have no back-to-back bypass: after the RESP handshake, IDLE lasts at least one cycle before the next acceptance.
REQ-029 SHALL ignore req_valid_i outside IDLE; req_data_i may change freely after acceptance.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE and clear the index, latched data, rsp_data_o and rsp_err_o to 0.
REQ-031 SHALL output after reset: req_ready_o=1, rsp_valid_o=0, mem_wen_o=0, mem_waddr_o=0, mem_wdata_o=0, mem_raddr_o=0.
REQ-032 SHALL, when reset is asserted mid-WRITE or mid-READ, abort the operation, issue no further writes from the edge where rst is sampled, and produce no response.

Structure
REQ-033 SHALL take DEPTH, AW, the state enum (IDLE/WRITE/READ/RESP) and the mode enum (WRVERIFY=0, RDONLY=1) from the shared package bitmem_pkg.
REQ-034 SHALL keep the index counter and FSM inline with no sub-module; the bench instantiates the existing 16x1 memory as the responder.

Verification
REQ-035 SHALL cover mode 0 with data 16'hA5C3 and rsp_ready_i=1: 16 writes to addr 0..15, rsp_valid_o 32 cycles after acceptance, rsp_data_o=16'hA5C3, rsp_err_o=0.
REQ-036 SHALL cover mode 1 after REQ-035: rsp_valid_o 16 cycles after acceptance, rsp_data_o=16'hA5C3, rsp_err_o=0, mem_wen_o never 1.
REQ-037 SHALL cover mode 0 with 16'hFFFF while the bench forces memory entry 7 to 0 on read: rsp_data_o=16'hFF7F, rsp_err_o=1.
REQ-038 SHALL cover rsp_ready_i held at 0 for 10 cycles: rsp_valid_o and rsp_data_o stay stable, req_ready_o=0, and a new req_valid_i is ignored.
REQ-039 SHALL cover rst=1 during WRITE at k=5: from the next edge mem_wen_o=0 and req_ready_o=1, entries 5..15 are unchanged, and no response is produced.
